// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync/active decodes, frame events
// and a short delay line aligning syncs with downstream draw stages.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        sof,
  output logic        vblank_start,
  output logic [7:0]  frame_count,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HT_M1  = 11'(H_TOTAL - 1);
  localparam logic [10:0] VT_M1  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_active;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_sof;
  logic        r_vbs;
  logic [7:0]  r_fc;

  logic        w_x_last;
  logic        w_y_last;
  logic [10:0] w_x_nxt;
  logic [10:0] w_y_nxt;
  logic        w_act_nxt;
  logic        w_hs_nxt;
  logic        w_vs_nxt;
  logic        w_sof_nxt;
  logic        w_vbs_nxt;

  // Next raster position and the decodes of that position, so levels
  // land on the same edge as the counters.
  always_comb begin
    w_x_last  = (r_x == HT_M1);
    w_y_last  = (r_y == VT_M1);
    w_x_nxt   = w_x_last ? 11'd0 : r_x + 11'd1;
    w_y_nxt   = r_y;
    if (w_x_last)
      w_y_nxt = w_y_last ? 11'd0 : r_y + 11'd1;
    w_act_nxt = (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
    w_hs_nxt  = !((w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END));
    w_vs_nxt  = !((w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END));
    w_sof_nxt = (w_x_nxt == 11'd0) && (w_y_nxt == 11'd0);
    w_vbs_nxt = (w_x_nxt == 11'd0) && (w_y_nxt == V_ACT);
  end

  // Counters and level decodes advance on ce; event pulses self-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x      <= HT_M1;
      r_y      <= VT_M1;
      r_active <= 1'b0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_sof    <= 1'b0;
      r_vbs    <= 1'b0;
      r_fc     <= 8'd0;
    end else begin
      r_sof <= 1'b0;
      r_vbs <= 1'b0;
      if (ce) begin
        r_x      <= w_x_nxt;
        r_y      <= w_y_nxt;
        r_active <= w_act_nxt;
        r_hsync  <= w_hs_nxt;
        r_vsync  <= w_vs_nxt;
        r_sof    <= w_sof_nxt;
        r_vbs    <= w_vbs_nxt;
        if (w_vbs_nxt)
          r_fc <= r_fc + 8'd1;
      end
    end
  end

  assign pixelX       = r_x;
  assign pixelY       = r_y;
  assign active       = r_active;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign sof          = r_sof;
  assign vblank_start = r_vbs;
  assign frame_count  = r_fc;

  if (SYNC_DELAY == 0) begin : g_nodly
    assign hsync_out  = r_hsync;
    assign vsync_out  = r_vsync;
    assign active_out = r_active;
  end else begin : g_dly
    // Each stage holds {hsync, vsync, active}.
    logic [2:0] r_dly [SYNC_DELAY];

    // Free-running shift, flushed to idle levels on reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < SYNC_DELAY; i++)
          r_dly[i] <= 3'b110;
      end else begin
        r_dly[0] <= {r_hsync, r_vsync, r_active};
        for (int i = 1; i < SYNC_DELAY; i++)
          r_dly[i] <= r_dly[i-1];
      end
    end

    assign hsync_out  = r_dly[SYNC_DELAY-1][2];
    assign vsync_out  = r_dly[SYNC_DELAY-1][1];
    assign active_out = r_dly[SYNC_DELAY-1][0];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-size and reduced-size raster generators
// against a linear-position frame model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  always #5 clk = ~clk;

  logic [10:0] a_px, a_py, b_px, b_py;
  logic a_act, a_hs, a_vs, a_sof, a_vb, a_hso, a_vso, a_aco;
  logic b_act, b_hs, b_vs, b_sof, b_vb, b_hso, b_vso, b_aco;
  logic [7:0] a_fc, b_fc;

  vga_timing_gen u_a (
    .clk(clk), .reset(reset), .ce(ce),
    .pixelX(a_px), .pixelY(a_py),
    .active(a_act), .hsync(a_hs), .vsync(a_vs),
    .sof(a_sof), .vblank_start(a_vb), .frame_count(a_fc),
    .hsync_out(a_hso), .vsync_out(a_vso), .active_out(a_aco)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_DELAY(3)
  ) u_b (
    .clk(clk), .reset(reset), .ce(ce),
    .pixelX(b_px), .pixelY(b_py),
    .active(b_act), .hsync(b_hs), .vsync(b_vs),
    .sof(b_sof), .vblank_start(b_vb), .frame_count(b_fc),
    .hsync_out(b_hso), .vsync_out(b_vso), .active_out(b_aco)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [47:0] got, logic [47:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // cfg: ha hfp hs hbp va vfp vs vbp delay
  int cfg [2][9];
  int pos [2];
  int fcnt [2];
  bit esof [2];
  bit evb [2];
  logic [2:0] hist [2][8];

  function automatic logic [2:0] levels(int k, int p);
    int ht, x, y, h0, v0;
    logic h, v, a;
    ht = cfg[k][0] + cfg[k][1] + cfg[k][2] + cfg[k][3];
    x  = p % ht;
    y  = p / ht;
    h0 = cfg[k][0] + cfg[k][1];
    v0 = cfg[k][4] + cfg[k][5];
    a  = (x < cfg[k][0]) && (y < cfg[k][4]);
    h  = !((x >= h0) && (x < h0 + cfg[k][2]));
    v  = !((y >= v0) && (y < v0 + cfg[k][6]));
    return {h, v, a};
  endfunction

  task automatic mstep(int k, bit r, bit c);
    int ht, ft;
    ht = cfg[k][0] + cfg[k][1] + cfg[k][2] + cfg[k][3];
    ft = ht * (cfg[k][4] + cfg[k][5] + cfg[k][6] + cfg[k][7]);
    esof[k] = 1'b0;
    evb[k]  = 1'b0;
    if (r) begin
      pos[k]  = ft - 1;
      fcnt[k] = 0;
      for (int i = 0; i < 8; i++) hist[k][i] = 3'b110;
    end else begin
      if (c) begin
        pos[k]  = (pos[k] + 1) % ft;
        esof[k] = (pos[k] == 0);
        evb[k]  = (pos[k] == cfg[k][4] * ht);
        if (evb[k]) fcnt[k] = (fcnt[k] + 1) % 256;
      end
      for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = levels(k, pos[k]);
    end
  endtask

  function automatic logic [47:0] expect_of(int k);
    int ht;
    logic [2:0] l, d;
    logic [10:0] x, y;
    ht = cfg[k][0] + cfg[k][1] + cfg[k][2] + cfg[k][3];
    x  = 11'(pos[k] % ht);
    y  = 11'(pos[k] / ht);
    l  = hist[k][0];
    d  = hist[k][cfg[k][8]];
    return {5'd0, x, y, l[0], l[2], l[1], esof[k], evb[k],
            8'(fcnt[k]), d[2], d[1], d[0]};
  endfunction

  function automatic logic [47:0] got_a();
    return {5'd0, a_px, a_py, a_act, a_hs, a_vs, a_sof, a_vb,
            a_fc, a_hso, a_vso, a_aco};
  endfunction

  function automatic logic [47:0] got_b();
    return {5'd0, b_px, b_py, b_act, b_hs, b_vs, b_sof, b_vb,
            b_fc, b_hso, b_vso, b_aco};
  endfunction

  task automatic cyc(bit r, bit c);
    reset = r;
    ce    = c;
    @(posedge clk);
    mstep(0, r, c);
    mstep(1, r, c);
    #1;
    chk("dutA", got_a(), expect_of(0));
    chk("dutB", got_b(), expect_of(1));
  endtask

  int hs_low, vs_low, sof_n, gap, last_sof, cnt;

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    cfg[1] = '{16, 2, 3, 3, 10, 2, 2, 3, 3};
    reset = 1'b1;
    ce    = 1'b0;

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("rst_xy", {a_px, a_py}, {11'd799, 11'd524});
    chk("rst_lv", {a_act, a_hs, a_vs, a_sof, a_vb, a_fc},
        {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    chk("rst_dly", {a_hso, a_vso, a_aco, b_hso, b_vso, b_aco},
        6'b110110);

    cyc(1'b0, 1'b1);
    chk("first_xy", {a_px, a_py}, 22'd0);
    chk("first_lv", {a_act, a_hs, a_vs, a_sof, a_fc},
        {1'b1, 1'b1, 1'b1, 1'b1, 8'd0});
    cyc(1'b0, 1'b0);
    chk("sof_clr", {a_sof, b_sof, a_px}, 13'd0);

    // alternating ce
    for (int i = 0; i < 60; i++) cyc(1'b0, (i % 2) == 0);

    // continuous ce: line/frame periodicity
    hs_low = 0; vs_low = 0; sof_n = 0; gap = 0; last_sof = -1;
    for (int i = 0; i < 1632; i++) begin
      cyc(1'b0, 1'b1);
      if (i < 1600 && !a_hs) hs_low++;
      if (i < 816) begin
        if (!b_vs) vs_low++;
        if (b_sof) sof_n++;
      end
      if (b_sof) begin
        if (last_sof >= 0) gap = i - last_sof;
        last_sof = i;
      end
    end
    chk("a_hs_low", 48'(hs_low), 48'd192);
    chk("b_vs_low", 48'(vs_low), 48'd96);
    chk("b_sof_n", 48'(sof_n), 48'd2);
    chk("b_sof_gap", 48'(gap), 48'd408);

    // a full small frame from reset: one vblank_start, frame_count 0->1
    cyc(1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 408; i++) begin
      cyc(1'b0, 1'b1);
      if (b_vb) begin
        cnt++;
        chk("b_vb_pos", {b_px, b_py}, {11'd0, 11'd10});
      end
    end
    chk("b_vb_once", 48'(cnt), 48'd1);
    chk("b_fc_1", 48'(b_fc), 48'd1);

    // mid-frame reset on the small raster
    while (!(b_px == 11'd5 && b_py == 11'd7)) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("mid_rst", {b_px, b_py, b_act, b_hs, b_vs, b_fc},
        {11'd23, 11'd16, 1'b0, 1'b1, 1'b1, 8'd0});

    // randomized ce and rare resets
    for (int i = 0; i < 20000; i++)
      cyc($urandom_range(0, 2999) == 0, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
